// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: blanking constants, hex segment table, scan states.
package seg7_pkg;

    // Cathode/anode patterns that leave the display dark (active-low).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} pattern for each hex value 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // A digit slot is a blanking gap followed by the lit period.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Display-value bus between the digit logic (master) and the scan driver (slave).
interface seven_seg_scan_driver_if;

    logic [15:0] digits_in;
    logic [3:0]  digit_en_in;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  AN;
    logic        frame_tick;
    logic        busy;

    modport master (
        output digits_in, digit_en_in, load,
        input  seg, AN, frame_tick, busy
    );

    modport slave (
        input  digits_in, digit_en_in, load,
        output seg, AN, frame_tick, busy
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Straight table lookup; every nibble value has an entry.
    always_comb begin
        seg = HEX_SEG[hex];
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed scan driver with frame-aligned double buffering
// and a blanking gap before each digit to suppress ghosting.
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned CNT_W        = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    seven_seg_scan_driver_if.slave  bus
);

    scan_state_t       state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [1:0]        idx_q, idx_d;
    logic              boundary;

    logic [15:0]       active_dig, pend_dig;
    logic [3:0]        active_en, pend_en;
    logic              busy_q;
    logic              frame_tick_q;

    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic [3:0]        show_nibble;
    logic [6:0]        dec_seg;

    // Decode whichever digit is about to be lit so the output can be registered.
    assign show_nibble = active_dig[{idx_d, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex (show_nibble),
        .seg (dec_seg)
    );

    // Scan state register: slot state, slot timer and digit index.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            timer_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: count out each phase, advance the digit after SHOW.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + CNT_W'(1);
        idx_d    = idx_q;
        boundary = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (timer_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_SHOW;
                    timer_d = '0;
                end
            end
            ST_SHOW: begin
                if (timer_q == CNT_W'(SHOW_CYCLES - 1)) begin
                    state_d  = ST_BLANK;
                    timer_d  = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = ST_BLANK;
                timer_d = '0;
            end
        endcase
    end

    // Output logic: light the upcoming digit only in SHOW and only if enabled.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        if (state_d == ST_SHOW && active_en[idx_d]) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = dec_seg;
        end
    end

    // Registered outputs, updated on the same edge as the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= boundary;
        end
    end

    // Double buffer: loads land in pending and commit to active at the frame
    // boundary; a load on the boundary edge itself goes straight to active.
    // NOTE: the display buffers are small registers, not RAM, and are reset
    // so a freshly reset board shows nothing until the first committed load.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_dig <= '0;
            active_en  <= '0;
            pend_dig   <= '0;
            pend_en    <= '0;
            busy_q     <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_dig <= bus.digits_in;
                pend_en  <= bus.digit_en_in;
            end
            if (boundary) begin
                busy_q <= 1'b0;
                if (bus.load) begin
                    active_dig <= bus.digits_in;
                    active_en  <= bus.digit_en_in;
                end else if (busy_q) begin
                    active_dig <= pend_dig;
                    active_en  <= pend_en;
                end
            end else if (bus.load) begin
                busy_q <= 1'b1;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.AN         = an_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for the scan driver with SHOW_CYCLES=4, BLANK_CYCLES=2
// (24-cycle frame). pos counts clock edges since the last frame boundary
// or reset; slot = pos/6, and phases 2..5 of each slot are the lit period.
module tb_seven_seg_scan_driver;

    localparam int FRAME = 24;

    // Segment codes, active-low {g..a}, indexed by hex value.
    localparam logic [6:0] S [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] BL = 7'h7F;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pos     = 0;
    logic armed   = 1'b0;

    seven_seg_scan_driver_if bus ();

    seven_seg_scan_driver #(
        .SHOW_CYCLES  (4),
        .BLANK_CYCLES (2),
        .CNT_W        (17)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Anodes may never have more than one digit enabled.
    always @(negedge clk) begin
        if (armed)
            check("an_onehot", 32'($countones(~bus.AN) <= 1), 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FRAME;
    endtask

    // Advance n cycles checking AN/seg/frame_tick/busy against the displayed
    // frame content (per-slot enable and segment code) and the expected busy.
    task automatic run_cycles(input int n, input logic [3:0] en,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic exp_busy);
        logic [6:0] segs [4];
        int         slot;
        logic       show;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        segs = '{s0, s1, s2, s3};
        for (int i = 0; i < n; i++) begin
            tick();
            slot    = pos / 6;
            show    = ((pos % 6) >= 2) && en[slot];
            exp_an  = show ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = show ? segs[slot] : BL;
            check($sformatf("an@%0d", pos),   32'(bus.AN),  32'(exp_an));
            check($sformatf("seg@%0d", pos),  32'(bus.seg), 32'(exp_seg));
            check($sformatf("tick@%0d", pos), 32'(bus.frame_tick), 32'(pos == 0));
            check($sformatf("busy@%0d", pos), 32'(bus.busy), 32'(exp_busy && pos != 0));
        end
    endtask

    task automatic start_load(input logic [15:0] d, input logic [3:0] en);
        bus.digits_in   = d;
        bus.digit_en_in = en;
        bus.load        = 1'b1;
    endtask

    logic [3:0] cur_en;
    logic [6:0] cur_s0;

    initial begin
        rst             = 1'b1;
        bus.load        = 1'b0;
        bus.digits_in   = 16'h0;
        bus.digit_en_in = 4'h0;

        // Reset held for two edges, then idle: a fully blank first frame.
        @(posedge clk);
        @(posedge clk);
        #1;
        armed = 1'b1;
        pos   = 0;
        check("rst_an",   32'(bus.AN),  32'hF);
        check("rst_seg",  32'(bus.seg), 32'(BL));
        check("rst_tick", 32'(bus.frame_tick), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        run_cycles(FRAME, 4'h0, BL, BL, BL, BL, 1'b0);
        run_cycles(FRAME, 4'h0, BL, BL, BL, BL, 1'b0);

        // Mid-frame load of 1234: busy until the boundary, then d0=4 .. d3=1.
        run_cycles(8, 4'h0, BL, BL, BL, BL, 1'b0);
        start_load(16'h1234, 4'hF);
        run_cycles(1, 4'h0, BL, BL, BL, BL, 1'b1);
        bus.load = 1'b0;
        run_cycles(15, 4'h0, BL, BL, BL, BL, 1'b1);
        run_cycles(FRAME, 4'hF, S[4], S[3], S[2], S[1], 1'b0);

        // ABCD with en=0101: slot 0 shows d, slot 2 shows b, slots 1/3 dark.
        run_cycles(3, 4'hF, S[4], S[3], S[2], S[1], 1'b0);
        start_load(16'hABCD, 4'b0101);
        run_cycles(1, 4'hF, S[4], S[3], S[2], S[1], 1'b1);
        bus.load = 1'b0;
        run_cycles(20, 4'hF, S[4], S[3], S[2], S[1], 1'b1);
        run_cycles(FRAME, 4'b0101, S[13], BL, S[11], BL, 1'b0);

        // Last-wins: 1111 then 2222 in one frame; only 2222 is ever shown.
        run_cycles(2, 4'b0101, S[13], BL, S[11], BL, 1'b0);
        start_load(16'h1111, 4'hF);
        run_cycles(1, 4'b0101, S[13], BL, S[11], BL, 1'b1);
        bus.load = 1'b0;
        run_cycles(5, 4'b0101, S[13], BL, S[11], BL, 1'b1);
        start_load(16'h2222, 4'hF);
        run_cycles(1, 4'b0101, S[13], BL, S[11], BL, 1'b1);
        bus.load = 1'b0;
        run_cycles(15, 4'b0101, S[13], BL, S[11], BL, 1'b1);
        run_cycles(FRAME, 4'hF, S[2], S[2], S[2], S[2], 1'b0);

        // Load on the boundary edge: commits at once, busy never rises.
        run_cycles(23, 4'hF, S[2], S[2], S[2], S[2], 1'b0);
        start_load(16'h5555, 4'hF);
        run_cycles(1, 4'hF, S[2], S[2], S[2], S[2], 1'b0);
        bus.load = 1'b0;
        run_cycles(FRAME, 4'hF, S[5], S[5], S[5], S[5], 1'b0);

        // Reset during digit 2 SHOW with a pending 9999: nothing is committed.
        run_cycles(14, 4'hF, S[5], S[5], S[5], S[5], 1'b0);
        start_load(16'h9999, 4'hF);
        run_cycles(1, 4'hF, S[5], S[5], S[5], S[5], 1'b1);
        bus.load = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        pos = 0;
        check("mrst_an",   32'(bus.AN),  32'hF);
        check("mrst_seg",  32'(bus.seg), 32'(BL));
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_tick", 32'(bus.frame_tick), 32'd0);
        rst = 1'b0;
        run_cycles(FRAME, 4'h0, BL, BL, BL, BL, 1'b0);
        run_cycles(FRAME, 4'h0, BL, BL, BL, BL, 1'b0);

        // Hex sweep on digit 0, each value loaded on the boundary edge.
        cur_en = 4'h0;
        cur_s0 = BL;
        for (int v = 0; v < 16; v++) begin
            run_cycles(23, cur_en, cur_s0, BL, BL, BL, 1'b0);
            start_load(16'(v), 4'b0001);
            run_cycles(1, cur_en, cur_s0, BL, BL, BL, 1'b0);
            bus.load = 1'b0;
            cur_en = 4'b0001;
            cur_s0 = S[v];
        end
        run_cycles(FRAME, cur_en, cur_s0, BL, BL, BL, 1'b0);

        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
